// File: rtl/modn_pkg.sv
// Shared encodings for the modulo-N cascade counter.
// Direction and boundary-mode values are named here so top and digits agree.
package modn_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/modn_digit.sv
// One modulo-MOD digit: clamped parallel load, up/down step with wrap,
// and a terminal flag (MOD-1 counting up, 0 counting down).
module modn_digit
  import modn_pkg::*;
#(
  parameter  int MOD = 10,
  localparam int DW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          step_in,
  input  logic          dir,
  input  logic          load_en,
  input  logic [DW-1:0] load_val,
  output logic [DW-1:0] q_digit,
  output logic          term_out
);

  localparam logic [DW-1:0] MAXV = DW'(MOD - 1);
  localparam logic [DW-1:0] ZERO = DW'(0);
  localparam logic [DW-1:0] ONE  = DW'(1);

  logic [DW-1:0] q_r;
  logic [DW-1:0] q_next_s;

  function automatic logic [DW-1:0] clamp_val(input logic [DW-1:0] v);
    if (v > MAXV) begin
      clamp_val = MAXV;
    end else begin
      clamp_val = v;
    end
  endfunction

  // next digit value: load wins, otherwise step with wrap, otherwise hold
  always_comb begin
    q_next_s = q_r;
    if (load_en) begin
      q_next_s = clamp_val(load_val);
    end else if (step_in) begin
      if (dir == DIR_UP) begin
        q_next_s = (q_r == MAXV) ? ZERO : (q_r + ONE);
      end else begin
        q_next_s = (q_r == ZERO) ? MAXV : (q_r - ONE);
      end
    end else begin
      q_next_s = q_r;
    end
  end

  // digit register with asynchronous clear
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      q_r <= ZERO;
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q_digit  = q_r;
  assign term_out = (dir == DIR_UP) ? (q_r == MAXV) : (q_r == ZERO);

endmodule

// File: rtl/modn_cascade_counter.sv
// NDIG cascaded modulo-MOD digits with single-cycle ripple carry/borrow,
// wrap or saturate at the full-count limit, and a registered wrap pulse.
module modn_cascade_counter
  import modn_pkg::*;
#(
  parameter  int MOD  = 10,
  parameter  int NDIG = 4,
  localparam int DW   = $clog2(MOD)
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               ena,
  input  logic               load,
  input  logic [NDIG*DW-1:0] din,
  input  logic               dir,
  input  logic               sat_mode,
  output logic [NDIG*DW-1:0] q,
  output logic               tc,
  output logic [0:0]         at_limit
);

  logic [NDIG-1:0] term_s;
  logic [NDIG-1:0] step_s;
  logic            load_en_s;
  logic            hold_s;
  logic            advance_s;
  logic            tc_next_s;
  logic            tc_r;

  assign load_en_s = ena & load;
  assign at_limit  = &term_s;
  assign hold_s    = (sat_mode == MODE_SAT) & at_limit;
  assign advance_s = ena & ~load & ~hold_s;

  // ripple enables: digit k steps only when every lower digit is terminal
  always_comb begin
    step_s    = '0;
    step_s[0] = advance_s;
    for (int k = 1; k < NDIG; k++) begin
      step_s[k] = step_s[k-1] & term_s[k-1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_digit
      modn_digit #(.MOD(MOD)) u_digit (
        .clk      (clk),
        .arst     (arst),
        .step_in  (step_s[g]),
        .dir      (dir),
        .load_en  (load_en_s),
        .load_val (din[g*DW +: DW]),
        .q_digit  (q[g*DW +: DW]),
        .term_out (term_s[g])
      );
    end
  endgenerate

  // a full-count wrap is exactly an advance taken while at the limit
  always_comb begin
    tc_next_s = 1'b0;
    if (advance_s && at_limit) begin
      tc_next_s = 1'b1;
    end else begin
      tc_next_s = 1'b0;
    end
  end

  // terminal-count pulse register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      tc_r <= 1'b0;
    end else begin
      tc_r <= tc_next_s;
    end
  end

  assign tc = tc_r;

endmodule

// File: tb/tb_modn_cascade_counter.sv
// Bench: directed and randomized checks of a MOD=10/NDIG=2 counter against an
// integer reference model, plus a MOD=16/NDIG=3 full-period run.
module tb_modn_cascade_counter;

  localparam int MOD  = 10;
  localparam int NTOT = 100;

  logic       clk = 1'b0;
  logic       arst;
  logic       ena, load, dir, sat_mode;
  logic [7:0] din;
  logic [7:0] q;
  logic       tc;
  logic [0:0] at_limit;

  logic        ena16, load16, dir16, sat16;
  logic [11:0] din16;
  logic [11:0] q16;
  logic        tc16;
  logic [0:0]  lim16;

  int n_cmp = 0;
  int n_err = 0;
  int mv    = 0;

  always #5 clk = ~clk;

  modn_cascade_counter #(.MOD(10), .NDIG(2)) dut (
    .clk(clk), .arst(arst), .ena(ena), .load(load), .din(din), .dir(dir),
    .sat_mode(sat_mode), .q(q), .tc(tc), .at_limit(at_limit)
  );

  modn_cascade_counter #(.MOD(16), .NDIG(3)) dut16 (
    .clk(clk), .arst(arst), .ena(ena16), .load(load16), .din(din16), .dir(dir16),
    .sat_mode(sat16), .q(q16), .tc(tc16), .at_limit(lim16)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // decimal value -> two packed 4-bit digits
  function automatic logic [7:0] to_q(input int v);
    int hi, lo;
    hi = (v / MOD) % MOD;
    lo = v % MOD;
    return {4'(hi), 4'(lo)};
  endfunction

  // packed load value -> decimal value with each digit clamped to 9
  function automatic int load_value(input logic [7:0] d);
    int hi, lo;
    hi = int'(d[7:4]);
    lo = int'(d[3:0]);
    if (hi > MOD - 1) hi = MOD - 1;
    if (lo > MOD - 1) lo = MOD - 1;
    return hi * MOD + lo;
  endfunction

  // one clock cycle from a negedge; model predicts, DUT is checked after the edge
  task automatic cyc(input logic e, input logic l, input logic [7:0] d,
                     input logic dr, input logic s);
    int   nv;
    logic etc, lim;
    ena = e; load = l; din = d; dir = dr; sat_mode = s;
    #1;
    lim = dr ? (mv == NTOT - 1) : (mv == 0);
    check_val("at_limit", 32'(at_limit), 32'(lim));
    nv  = mv;
    etc = 1'b0;
    if (e) begin
      if (l) nv = load_value(d);
      else if (lim && s) nv = mv;
      else begin
        nv  = dr ? (mv + 1) % NTOT : (mv + NTOT - 1) % NTOT;
        etc = lim;
      end
    end
    @(posedge clk);
    #1;
    mv = nv;
    check_val("q", 32'(q), 32'(to_q(mv)));
    check_val("tc", 32'(tc), 32'(etc));
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    dir  = 1'b0;
    arst = 1'b0;
    #1;
    mv = 0;
    check_val("rst_q", 32'(q), 32'h0);
    check_val("rst_tc", 32'(tc), 32'h0);
    check_val("rst_at_limit_down", 32'(at_limit), 32'h1);
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    int tc_cnt;
    logic rd, rs;
    arst = 1'b0; ena = 1'b0; load = 1'b0; din = 8'h00; dir = 1'b1; sat_mode = 1'b0;
    ena16 = 1'b0; load16 = 1'b0; din16 = 12'h000; dir16 = 1'b1; sat16 = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_q", 32'(q), 32'h0);
    check_val("reset_tc", 32'(tc), 32'h0);
    arst = 1'b1;

    // async reset from 57, then count 3 up
    cyc(1'b1, 1'b1, 8'h57, 1'b1, 1'b0);
    check_val("load57", 32'(q), 32'h57);
    async_reset();
    repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("after_rst_03", 32'(q), 32'h03);

    // clamped load, then wrap with tc
    cyc(1'b1, 1'b1, {4'd12, 4'd15}, 1'b1, 1'b0);
    check_val("clamp99", 32'(q), 32'h99);
    check_val("load_tc0", 32'(tc), 32'h0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("wrap00", 32'(q), 32'h00);
    check_val("wrap_tc1", 32'(tc), 32'h1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("tc_one_cycle", 32'(tc), 32'h0);

    // carry and borrow ripple
    cyc(1'b1, 1'b1, 8'h09, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check_val("carry10", 32'(q), 32'h10);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("borrow09", 32'(q), 32'h09);

    // saturation hold and release on direction reversal
    cyc(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    repeat (5) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    check_val("sat_hold99", 32'(q), 32'h99);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    check_val("sat_release98", 32'(q), 32'h98);

    // down wrap with ena toggling
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("down_wrap99", 32'(q), 32'h99);
    check_val("down_wrap_tc", 32'(tc), 32'h1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("ena0_hold99", 32'(q), 32'h99);
    check_val("ena0_tc0", 32'(tc), 32'h0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check_val("ena1_98", 32'(q), 32'h98);

    // load overrides saturation at the limit
    cyc(1'b1, 1'b1, 8'h99, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 8'h45, 1'b1, 1'b1);
    check_val("load_over_sat", 32'(q), 32'h45);

    // randomized traffic, direction and mode fairly sticky to reach limits
    rd = 1'b1; rs = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rd = ~rd;
      if ($urandom_range(0, 31) == 0) rs = ~rs;
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cyc(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 40) == 0),
            8'($urandom), rd, rs);
      end
    end

    // full-period run of the 16x3 instance starting from 000
    async_reset();
    check_val("m16_start", 32'(q16), 32'h0);
    tc_cnt = 0;
    ena16  = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      @(posedge clk);
      #1;
      if (tc16) tc_cnt++;
      if (i % 256 == 255) check_val("m16_q", 32'(q16), 32'((i + 1) % 4096));
    end
    @(negedge clk);
    ena16 = 1'b0;
    check_val("m16_end_000", 32'(q16), 32'h0);
    check_val("m16_tc_count", 32'(tc_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
